// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-side memory responder:
//   - RISC-V funct3 size/sign codes used by loads and stores
//   - responder FSM state encoding
//   - byte-lane count of a 32-bit word
//   - helpers that classify a funct3 code as a legal load or store
// ---------------------------------------------------------------------------
package mem_pkg;

    // Number of byte lanes in a 32-bit data word (width of byte enables).
    localparam int BE_W = 4;

    // funct3 encodings for the RV32I load/store family.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic f3_load_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_store_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a 32-bit word memory.
// Ports:
//   f3         in  3   funct3 size/sign code
//   addr_lo    in  2   byte offset within the word (addr[1:0])
//   wdata      in  32  store data, value in the low lanes
//   raw_word   in  32  word read from the addressed location
//   be         out 4   byte enables for a store (0 for non-store codes)
//   wdata_lane out 32  store data replicated onto every lane it may hit
//   rdata_ext  out 32  load data shifted down and sign/zero extended
//   misalign   out 1   half access at an odd address or word access at a
//                      non-word-aligned address
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]      f3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     raw_word,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_lane,
    output logic [31:0]     rdata_ext,
    output logic            misalign
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = raw_word >> {addr_lo, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        be         = '0;
        wdata_lane = wdata;
        rdata_ext  = '0;
        misalign   = 1'b0;
        unique case (f3)
            F3_B: begin
                be         = BE_W'(1) << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                rdata_ext  = {24'b0, byte_sel};
            end
            F3_H: begin
                misalign   = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                misalign   = addr_lo[0];
                rdata_ext  = {16'b0, half_sel};
            end
            F3_W: begin
                misalign   = |addr_lo;
                be         = 4'b1111;
                rdata_ext  = raw_word;
            end
            default: begin
                // Illegal codes are flagged by the parent; outputs stay idle.
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Target end of the RV32I core's load/store interface. Holds a byte-lane
// word RAM, a memory-mapped synchronised key status register and a
// programmable wait-state FSM (IDLE -> [BUSY] -> DONE -> IDLE).
// Parameters:
//   DEPTH_WORDS  number of 32-bit RAM words (byte span DEPTH_WORDS*4)
//   WAIT_CYCLES  extra busy cycles per access (0 legal)
//   KEY_ADDR     word-aligned MMIO address of the key register; must lie
//                outside the RAM span
// Ports:
//   clk    in  1   system clock, rising edge
//   rst    in  1   asynchronous active-high reset
//   req    in  1   access request, sampled only in IDLE
//   we     in  1   1 = store, 0 = load
//   f3     in  3   funct3 (size/sign)
//   addr   in  32  byte address
//   wdata  in  32  store data, value in low lanes
//   key    in  1   asynchronous push-button
//   rdata  out 32  load result, held until the next load completion
//   ready  out 1   one-cycle completion pulse
//   err    out 1   one-cycle fault pulse, coincident with ready
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] KEY_ADDR    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        key,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = $clog2(WAIT_CYCLES + 2);
    localparam logic [32:0] RAM_SPAN = 33'(DEPTH_WORDS) * 33'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    // Access fields captured when the request is accepted.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic key_meta, key_s;

    // Decode and datapath.
    logic             ram_sel, key_sel, unmapped, f3_ok, acc_err;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      raw_word;
    logic [BE_W-1:0]  be;
    logic [31:0]      wdata_lane, rdata_ext;
    logic             misalign;

    // Registered-output next values and RAM write strobe.
    logic        ram_we;
    logic        ready_d, err_d;
    logic [31:0] rdata_d;

    logic [31:0] ram [DEPTH_WORDS];

    // ---------------- state register (FSM process 1) ----------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Request capture and wait counter. Fields load only when a request is
    // accepted in IDLE, so later input changes cannot disturb an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
        end else if (state_q == ST_IDLE && req) begin
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= f3;
            we_q    <= we;
        end else if (state_q == ST_BUSY) begin
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end

    // ---------------- next-state logic (FSM process 2) ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = (WAIT_CYCLES > 0) ? ST_BUSY : ST_DONE;
            // Counter starts at WAIT_CYCLES, so BUSY lasts WAIT_CYCLES cycles.
            ST_BUSY: if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- address decode and lane steering ----------------
    assign ram_sel  = {1'b0, addr_q} < RAM_SPAN;
    assign key_sel  = (addr_q == KEY_ADDR);
    assign unmapped = !ram_sel && !key_sel;
    assign ram_idx  = addr_q[IDX_W+1:2];
    assign f3_ok    = we_q ? f3_store_ok(f3_q) : f3_load_ok(f3_q);
    assign acc_err  = !f3_ok || misalign || unmapped;

    always_comb begin
        raw_word = '0;
        if (ram_sel)      raw_word = ram[ram_idx];
        else if (key_sel) raw_word = {31'b0, key_s};
    end

    mem_lane_align u_align (
        .f3         (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .raw_word   (raw_word),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    // ---------------- output logic (FSM process 3) ----------------
    // DONE decides the completion; the result is registered on the edge that
    // leaves DONE, so ready/err/rdata appear together one cycle later.
    always_comb begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata;
        ram_we  = 1'b0;
        if (state_q == ST_DONE) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            if (we_q) ram_we  = ram_sel && !acc_err;   // key writes are dropped silently
            else      rdata_d = acc_err ? 32'b0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= ready_d;
            err   <= err_d;
            rdata <= rdata_d;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive rst, and an
    // access aborted by rst never reaches DONE, so it never writes.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders share one clock and reset: dut0 with WAIT_CYCLES=1 and dut1
// with WAIT_CYCLES=0. Each access pushes its expected rdata, err and latency
// into a queue; a negedge monitor pops and compares whenever a ready pulses.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam logic [31:0] KEY_ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, key, req0, req1, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, err0, err1;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .KEY_ADDR(KEY_ADDR)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .f3(f3), .addr(addr), .wdata(wdata),
        .key(key), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .KEY_ADDR(KEY_ADDR)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .f3(f3), .addr(addr), .wdata(wdata),
        .key(key), .rdata(rdata1), .ready(ready1), .err(err1)
    );

    typedef struct {
        int          dut;
        int          tag;
        logic [31:0] rdata;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          tag_n = 0;
    logic [31:0] mrd [2];     // model of each DUT's rdata register

    logic [1:0]  rdy_v, err_v;
    logic [31:0] rd_v [2];
    assign rdy_v   = {ready1, ready0};
    assign err_v   = {err1, err0};
    assign rd_v[0] = rdata0;
    assign rd_v[1] = rdata1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: decoupled from stimulus, pops one expectation per ready pulse.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (err_v[d] && !rdy_v[d])
                    check($sformatf("dut%0d err without ready", d), 32'(err_v[d]), 32'(rdy_v[d]));
                if (rdy_v[d]) begin
                    if (q.size() == 0) begin
                        check($sformatf("dut%0d unexpected ready", d), 32'(rdy_v[d]), 32'd0);
                    end else begin
                        cur = q.pop_front();
                        check($sformatf("acc%0d dut id", cur.tag), 32'(d), 32'(cur.dut));
                        check($sformatf("acc%0d rdata", cur.tag), rd_v[d], cur.rdata);
                        check($sformatf("acc%0d err", cur.tag), 32'(err_v[d]), 32'(cur.err));
                        check($sformatf("acc%0d latency", cur.tag), 32'(cyc - cur.issue), 32'(cur.lat));
                    end
                end
            end
        end
    end

    // Issue one access, push its expectation, wait (bounded) for completion.
    task automatic access(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
        exp_t e;
        @(posedge clk); #1;
        we = w; f3 = f; addr = a; wdata = wd;
        if (d == 0) req0 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        // Scramble the inputs: the DUT must work from its captured copy.
        we = ~w; f3 = 3'b111; addr = 32'hFFFF_FFFC; wdata = ~wd;
        e.dut = d; e.tag = tag_n; e.rdata = exp_rd; e.err = exp_er;
        e.issue = cyc; e.lat = (d == 0) ? 2 : 1;
        q.push_back(e);
        tag_n++;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            check($sformatf("acc%0d completion timeout", e.tag), 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic ld(input int d, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_er);
        mrd[d] = exp_rd;
        access(d, 1'b0, f, a, 32'h0, exp_rd, exp_er);
    endtask

    task automatic st(input int d, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_er);
        access(d, 1'b1, f, a, wd, mrd[d], exp_er);
    endtask

    int ready_seen;

    initial begin
        rst = 1'b1; key = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
        mrd[0] = '0; mrd[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rdata0", rdata0, 32'h0);
        check("reset ready0", 32'(ready0), 32'd0);
        check("reset err0", 32'(err0), 32'd0);
        check("reset rdata1", rdata1, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Word store/load and byte lanes (WAIT_CYCLES=1).
        st(0, F3_W,  32'h10, 32'hDEAD_BEEF, 1'b0);
        ld(0, F3_W,  32'h10, 32'hDEAD_BEEF, 1'b0);
        st(0, F3_B,  32'h11, 32'h0000_0080, 1'b0);
        ld(0, F3_B,  32'h11, 32'hFFFF_FF80, 1'b0);
        ld(0, F3_BU, 32'h11, 32'h0000_0080, 1'b0);
        ld(0, F3_W,  32'h10, 32'hDEAD_80EF, 1'b0);
        ld(0, F3_H,  32'h12, 32'hFFFF_DEAD, 1'b0);
        ld(0, F3_HU, 32'h12, 32'h0000_DEAD, 1'b0);

        // Halfword store into a known word.
        st(0, F3_W,  32'h20, 32'hA5A5_5A5A, 1'b0);
        st(0, F3_H,  32'h22, 32'hFFFF_1234, 1'b0);
        ld(0, F3_H,  32'h22, 32'h0000_1234, 1'b0);
        ld(0, F3_W,  32'h20, 32'h1234_5A5A, 1'b0);

        // Misalignment and illegal funct3.
        ld(0, F3_W,  32'h13, 32'h0, 1'b1);
        st(0, F3_W,  32'h14, 32'h1122_3344, 1'b0);
        st(0, F3_W,  32'h16, 32'h9999_9999, 1'b1);
        ld(0, F3_W,  32'h14, 32'h1122_3344, 1'b0);
        ld(0, 3'b011, 32'h10, 32'h0, 1'b1);
        st(0, F3_BU, 32'h10, 32'h0000_0000, 1'b1);
        ld(0, F3_W,  32'h10, 32'hDEAD_80EF, 1'b0);

        // Key register and unmapped space.
        ld(0, F3_W,  KEY_ADDR, 32'h0, 1'b0);
        key = 1'b1;
        repeat (3) @(posedge clk);
        ld(0, F3_W,  KEY_ADDR, 32'h1, 1'b0);
        ld(0, F3_B,  KEY_ADDR, 32'h1, 1'b0);
        st(0, F3_W,  KEY_ADDR, 32'hFFFF_FFFF, 1'b0);
        ld(0, F3_W,  32'h2000, 32'h0, 1'b1);
        ld(0, F3_W,  KEY_ADDR, 32'h1, 1'b0);

        // Reset during BUSY aborts the store.
        st(0, F3_W,  32'h30, 32'h0BAD_F00D, 1'b0);
        @(posedge clk); #1;
        we = 1'b1; f3 = F3_W; addr = 32'h30; wdata = 32'h55; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("abort rst rdata0", rdata0, 32'h0);
        check("abort rst ready0", 32'(ready0), 32'd0);
        check("abort rst err0", 32'(err0), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        mrd[0] = '0; mrd[1] = '0;
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready0) ready_seen++;
        end
        check("abort no ready", 32'(ready_seen), 32'd0);
        ld(0, F3_W,  32'h30, 32'h0BAD_F00D, 1'b0);

        // Zero wait states: ready one cycle after the sampling edge.
        st(1, F3_W,  32'h40, 32'h0F0F_0F0F, 1'b0);
        ld(1, F3_W,  32'h40, 32'h0F0F_0F0F, 1'b0);
        ld(1, F3_B,  32'h41, 32'h0000_000F, 1'b0);
        ld(1, F3_H,  32'h41, 32'h0, 1'b1);
        st(1, F3_B,  32'h43, 32'h0000_00F0, 1'b0);
        ld(1, F3_W,  32'h40, 32'hF00F_0F0F, 1'b0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
